// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit constants and converter state encoding.
// Used by both the BCD-to-binary and binary-to-BCD paths.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_VAL    = 4'd3;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;
endpackage

// File: rtl/bcd_nibble_corr.sv
// bcd_nibble_corr: undoes the double-dabble +3 on one BCD digit after a right shift.
module bcd_nibble_corr
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    always_comb dout = (din >= CORR_THRESH) ? din - CORR_VAL : din;
endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double-dabble, N shift cycles).
// Optional BCD_ERR_EN: reject operands holding a digit above 9 with err=1 after one cycle.
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic [N-1:0]              binary,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic                      err
);
    localparam int BW = DIGIT_W * DIGITS;
    localparam int SW = BW + N;
    localparam int CW = $clog2(N + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic [N-1:0]    bin_q, bin_d;
    logic            busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d;
    logic [SW-1:0]   shifted, stepped;
    logic [BW-1:0]   corr;
    logic            bad;

    assign shifted = sreg_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_corr u_corr (
            .din  (shifted[N+DIGIT_W*g +: DIGIT_W]),
            .dout (corr[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign stepped = {corr, shifted[N-1:0]};

`ifdef BCD_ERR_EN
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) bad = bad | (bcd_in[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX);
    end
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        bin_d   = bin_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                if (bad) begin
                    state_d = DONE;
                    bin_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = SHIFT;
                    sreg_d  = {bcd_in, {N{1'b0}}};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                sreg_d = stepped;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    // whatever is left in the BCD field is the quotient by 2**N
                    state_d = DONE;
                    bin_d   = stepped[N-1:0];
                    ovf_d   = |stepped[SW-1:N];
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign binary = bin_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign err    = err_q;
endmodule
